// File: rtl/fpga_boot_sequencer_if.sv
// -----------------------------------------------------------------------------
// fpga_boot_sequencer_if
//   Groups the SoC exit-reporting handshake between the SoC and the boot
//   sequencer.
//
//   exit_valid_i  SoC -> sequencer  one-cycle flag, synchronous to clk_gen
//   exit_value_i  SoC -> sequencer  32-bit exit value qualified by exit_valid_i
//   exit_value_o  sequencer -> SoC  captured exit value
//   done_o        sequencer -> SoC  high while the sequencer is in DONE
//
//   master: the SoC side (drives the exit flag and value)
//   slave : the boot sequencer side
// -----------------------------------------------------------------------------
interface fpga_boot_sequencer_if;
  logic        exit_valid_i;
  logic [31:0] exit_value_i;
  logic [31:0] exit_value_o;
  logic        done_o;

  modport master (
    output exit_valid_i,
    output exit_value_i,
    input  exit_value_o,
    input  done_o
  );

  modport slave (
    input  exit_valid_i,
    input  exit_value_i,
    output exit_value_o,
    output done_o
  );
endinterface

// File: rtl/fpga_boot_sequencer.sv
// -----------------------------------------------------------------------------
// fpga_boot_sequencer
//   Brings an SoC out of reset once the clock wizard is locked, latches the
//   boot straps at the end of the reset hold, captures the SoC exit value and
//   lets a debounced push-button restart the SoC.
//
//   Parameters
//     DEBOUNCE_CYCLES  consecutive stable cycles before a button level is taken
//     HOLD_CYCLES      SoC reset assertion length in cycles
//
//   Ports
//     clk_gen               system clock, rising edge
//     rst_n                 asynchronous active-low reset
//     pll_locked_i          clock wizard lock (asynchronous)
//     btn_rst_i             raw bouncing push-button, active-high (asynchronous)
//     boot_select_i         raw boot strap
//     execute_from_flash_i  raw flash-execute strap
//     soc                   exit handshake (exit_valid_i/exit_value_i in,
//                           exit_value_o/done_o out)
//     soc_rst_no            SoC reset, active-low, registered
//     boot_select_o         latched boot strap
//     execute_from_flash_o  latched flash strap
//     state_o               LED state code: WAIT_LOCK=0 HOLD=1 RUN=2 DONE=3
// -----------------------------------------------------------------------------
module fpga_boot_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int HOLD_CYCLES     = 256
) (
  input  logic                        clk_gen,
  input  logic                        rst_n,
  input  logic                        pll_locked_i,
  input  logic                        btn_rst_i,
  input  logic                        boot_select_i,
  input  logic                        execute_from_flash_i,
  fpga_boot_sequencer_if.slave        soc,
  output logic                        soc_rst_no,
  output logic                        boot_select_o,
  output logic                        execute_from_flash_o,
  output logic [1:0]                  state_o
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // bit 0: pll lock, bit 1: push-button
  logic [1:0] meta_reg;
  logic [1:0] sync_reg;
  logic       lock_sync;
  logic       btn_sync;

  logic [DB_W-1:0]   db_cnt_reg;
  logic              btn_db_reg;
  logic              btn_press_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic              hold_last;
  logic              enter_hold;
  logic              capture_exit;
  logic              latch_straps;

  logic              soc_rst_n_reg;
  logic              boot_select_reg;
  logic              execute_from_flash_reg;
  logic [31:0]       exit_value_reg;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizers for the asynchronous lock and button inputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 2'b00;
      sync_reg <= 2'b00;
    end else begin
      meta_reg <= {btn_rst_i, pll_locked_i};
      sync_reg <= meta_reg;
    end
  end

  assign lock_sync = sync_reg[0];
  assign btn_sync  = sync_reg[1];

  // ---------------------------------------------------------------------------
  // Button debounce: the debounced level only follows the synchronized level
  // after it has disagreed for DEBOUNCE_CYCLES cycles in a row. The press pulse
  // is raised on the same edge that btn_db_reg goes 0 -> 1.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_reg    <= '0;
      btn_db_reg    <= 1'b0;
      btn_press_reg <= 1'b0;
    end else if (btn_sync != btn_db_reg) begin
      if (db_cnt_reg == DB_LAST) begin
        db_cnt_reg    <= '0;
        btn_db_reg    <= btn_sync;
        btn_press_reg <= btn_sync;
      end else begin
        db_cnt_reg    <= db_cnt_reg + DB_W'(1);
        btn_press_reg <= 1'b0;
      end
    end else begin
      db_cnt_reg    <= '0;
      btn_press_reg <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  assign hold_last = (hold_cnt_reg == HOLD_LAST);

  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= WAIT_LOCK;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    // Loss of lock overrides every other event, including button and exit.
    if (!lock_sync) begin
      state_next = WAIT_LOCK;
    end else begin
      unique case (state_reg)
        WAIT_LOCK: state_next = HOLD;
        HOLD:      if (hold_last) state_next = RUN;
        // A button press beats a simultaneous exit report.
        RUN: begin
          if (btn_press_reg)          state_next = HOLD;
          else if (soc.exit_valid_i)  state_next = DONE;
        end
        DONE:      if (btn_press_reg) state_next = HOLD;
        default:   state_next = WAIT_LOCK;
      endcase
    end
  end

  assign enter_hold   = (state_next == HOLD) && (state_reg != HOLD);
  assign capture_exit = (state_reg == RUN) && (state_next == DONE);
  assign latch_straps = (state_reg == HOLD) && (state_next == RUN);

  // Hold counter saturates at its last value instead of wrapping.
  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_reg <= '0;
    end else if (enter_hold) begin
      hold_cnt_reg <= '0;
    end else if ((state_reg == HOLD) && !hold_last) begin
      hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
    end
  end

  // Registered outputs; SoC reset follows the next state so it changes on the
  // same edge as the state and never glitches.
  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      soc_rst_n_reg          <= 1'b0;
      boot_select_reg        <= 1'b0;
      execute_from_flash_reg <= 1'b0;
      exit_value_reg         <= 32'h0;
    end else begin
      soc_rst_n_reg <= (state_next == RUN) || (state_next == DONE);
      if (latch_straps) begin
        boot_select_reg        <= boot_select_i;
        execute_from_flash_reg <= execute_from_flash_i;
      end
      if (enter_hold) begin
        exit_value_reg <= 32'h0;
      end else if (capture_exit) begin
        exit_value_reg <= soc.exit_value_i;
      end
    end
  end

  assign soc_rst_no           = soc_rst_n_reg;
  assign boot_select_o        = boot_select_reg;
  assign execute_from_flash_o = execute_from_flash_reg;
  assign soc.exit_value_o     = exit_value_reg;
  assign soc.done_o           = (state_reg == DONE);
  assign state_o              = state_reg;

endmodule

// File: tb/tb_fpga_boot_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fpga_boot_sequencer
//   Scenario-driven bench for fpga_boot_sequencer with a small event-level
//   reference model (expected state, captured exit value, latched straps).
// -----------------------------------------------------------------------------
module tb_fpga_boot_sequencer;

  localparam int D = 16;  // debounce length
  localparam int H = 8;   // reset hold length

  // Expected LED codes
  localparam logic [1:0] S_WAIT = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic       clk_gen = 1'b0;
  logic       rst_n;
  logic       pll_locked_i;
  logic       btn_rst_i;
  logic       boot_select_i;
  logic       execute_from_flash_i;
  logic       soc_rst_no;
  logic       boot_select_o;
  logic       execute_from_flash_o;
  logic [1:0] state_o;

  fpga_boot_sequencer_if soc_bus ();

  fpga_boot_sequencer #(
    .DEBOUNCE_CYCLES (D),
    .HOLD_CYCLES     (H)
  ) dut (
    .clk_gen              (clk_gen),
    .rst_n                (rst_n),
    .pll_locked_i         (pll_locked_i),
    .btn_rst_i            (btn_rst_i),
    .boot_select_i        (boot_select_i),
    .execute_from_flash_i (execute_from_flash_i),
    .soc                  (soc_bus),
    .soc_rst_no           (soc_rst_no),
    .boot_select_o        (boot_select_o),
    .execute_from_flash_o (execute_from_flash_o),
    .state_o              (state_o)
  );

  always #5 clk_gen = ~clk_gen;

  int total = 0;
  int bad   = 0;

  // Reference model: what the outputs must be, from the behavioural rules.
  logic [1:0]  m_state;
  logic [31:0] m_exit;
  logic        m_boot;
  logic        m_flash;

  // Advance n rising edges, leaving time 1 ns after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_gen);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pll_locked_i = 1'b0; btn_rst_i = 1'b0;
    boot_select_i = 1'b0; execute_from_flash_i = 1'b0;
    soc_bus.exit_valid_i = 1'b0; soc_bus.exit_value_i = 32'h0;
    m_state = S_WAIT; m_exit = 32'h0; m_boot = 1'b0; m_flash = 1'b0;
    tick(3);
    total++; if (state_o !== S_WAIT) begin bad++; $display("FAIL reset_state got=%0d want=%0d", state_o, S_WAIT); end
    total++; if (soc_rst_no !== 1'b0) begin bad++; $display("FAIL reset_soc_rst got=%0b want=0", soc_rst_no); end
    total++; if ({boot_select_o, execute_from_flash_o, soc_bus.done_o} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%03b want=000", {boot_select_o, execute_from_flash_o, soc_bus.done_o}); end
    total++; if (soc_bus.exit_value_o !== 32'h0) begin bad++; $display("FAIL reset_exit got=%08h want=00000000", soc_bus.exit_value_o); end
    rst_n = 1'b1;
    tick(5);
    total++; if (state_o !== S_WAIT || soc_rst_no !== 1'b0) begin bad++; $display("FAIL nolock_wait got=%0d/%0b want=%0d/0", state_o, soc_rst_no, S_WAIT); end
    $display("test_reset done");
  endtask

  // Lock rise: HOLD three edges later, RUN H edges after that, straps sampled
  // from the last HOLD cycle only.
  task automatic test_boot(input logic boot_v, input logic flash_v);
    pll_locked_i = 1'b1;
    tick(2);
    total++; if (state_o !== S_WAIT) begin bad++; $display("FAIL boot_early got=%0d want=%0d", state_o, S_WAIT); end
    tick(1);
    m_state = S_HOLD; m_exit = 32'h0;
    total++; if (state_o !== m_state || soc_rst_no !== 1'b0) begin bad++; $display("FAIL boot_hold got=%0d/%0b want=%0d/0", state_o, soc_rst_no, m_state); end
    boot_select_i = ~boot_v; execute_from_flash_i = ~flash_v;
    tick(H - 1);
    total++; if (state_o !== S_HOLD || soc_rst_no !== 1'b0) begin bad++; $display("FAIL boot_hold_end got=%0d/%0b want=%0d/0", state_o, soc_rst_no, S_HOLD); end
    boot_select_i = boot_v; execute_from_flash_i = flash_v;
    m_boot = boot_v; m_flash = flash_v;
    tick(1);
    m_state = S_RUN;
    total++; if (state_o !== m_state || soc_rst_no !== 1'b1) begin bad++; $display("FAIL boot_run got=%0d/%0b want=%0d/1", state_o, soc_rst_no, m_state); end
    total++; if (boot_select_o !== m_boot || execute_from_flash_o !== m_flash) begin bad++; $display("FAIL boot_straps got=%0b%0b want=%0b%0b", boot_select_o, execute_from_flash_o, m_boot, m_flash); end
    boot_select_i = ~boot_v; execute_from_flash_i = ~flash_v;
    tick(3);
    total++; if (boot_select_o !== m_boot || execute_from_flash_o !== m_flash) begin bad++; $display("FAIL straps_stable got=%0b%0b want=%0b%0b", boot_select_o, execute_from_flash_o, m_boot, m_flash); end
    $display("test_boot boot=%0b flash=%0b done", boot_v, flash_v);
  endtask

  task automatic test_exit(input logic [31:0] val, input int gap);
    tick(gap);
    soc_bus.exit_valid_i = 1'b1; soc_bus.exit_value_i = val;
    tick(1);
    soc_bus.exit_valid_i = 1'b0; soc_bus.exit_value_i = 32'h0;
    m_state = S_DONE; m_exit = val;
    total++; if (state_o !== m_state || soc_bus.done_o !== 1'b1) begin bad++; $display("FAIL exit_done got=%0d/%0b want=%0d/1", state_o, soc_bus.done_o, m_state); end
    total++; if (soc_bus.exit_value_o !== m_exit) begin bad++; $display("FAIL exit_value got=%08h want=%08h", soc_bus.exit_value_o, m_exit); end
    $display("test_exit value=%08h gap=%0d done", val, gap);
  endtask

  task automatic test_exit_ignored();
    tick(2);
    soc_bus.exit_valid_i = 1'b1; soc_bus.exit_value_i = 32'hDEAD_BEEF;
    tick(1);
    soc_bus.exit_valid_i = 1'b0;
    tick(2);
    total++; if (state_o !== S_DONE || soc_bus.exit_value_o !== m_exit) begin bad++; $display("FAIL done_ignore got=%0d/%08h want=%0d/%08h", state_o, soc_bus.exit_value_o, S_DONE, m_exit); end
    $display("test_exit_ignored done");
  endtask

  // 10-cycle pulses never reach the debounce length, so nothing happens.
  task automatic test_bounce();
    logic [1:0] st0;
    st0 = m_state;
    for (int i = 0; i < 4; i++) begin
      btn_rst_i = 1'b1; tick(10);
      btn_rst_i = 1'b0; tick(10);
    end
    tick(D + 4);
    total++; if (state_o !== st0 || soc_rst_no !== 1'b1) begin bad++; $display("FAIL bounce_state got=%0d/%0b want=%0d/1", state_o, soc_rst_no, st0); end
    total++; if (soc_bus.exit_value_o !== m_exit) begin bad++; $display("FAIL bounce_exit got=%08h want=%08h", soc_bus.exit_value_o, m_exit); end
    $display("test_bounce done");
  endtask

  // Held button: 2 sync + D debounce edges, then the FSM reacts on the next.
  task automatic test_button(input logic boot_v, input logic flash_v);
    logic [1:0] st0;
    st0 = m_state;
    btn_rst_i = 1'b1;
    tick(2 + D);
    total++; if (state_o !== st0) begin bad++; $display("FAIL button_early got=%0d want=%0d", state_o, st0); end
    tick(1);
    btn_rst_i = 1'b0;
    m_state = S_HOLD; m_exit = 32'h0;
    total++; if (state_o !== m_state || soc_rst_no !== 1'b0) begin bad++; $display("FAIL button_hold got=%0d/%0b want=%0d/0", state_o, soc_rst_no, m_state); end
    total++; if (soc_bus.exit_value_o !== m_exit || soc_bus.done_o !== 1'b0) begin bad++; $display("FAIL button_clear got=%08h/%0b want=00000000/0", soc_bus.exit_value_o, soc_bus.done_o); end
    boot_select_i = boot_v; execute_from_flash_i = flash_v;
    m_boot = boot_v; m_flash = flash_v;
    tick(H);
    m_state = S_RUN;
    total++; if (state_o !== m_state || soc_rst_no !== 1'b1) begin bad++; $display("FAIL button_run got=%0d/%0b want=%0d/1", state_o, soc_rst_no, m_state); end
    total++; if (boot_select_o !== m_boot || execute_from_flash_o !== m_flash) begin bad++; $display("FAIL button_straps got=%0b%0b want=%0b%0b", boot_select_o, execute_from_flash_o, m_boot, m_flash); end
    tick(D + 4);  // let the release debounce settle
    $display("test_button done");
  endtask

  task automatic test_coincide(input logic [31:0] val);
    btn_rst_i = 1'b1;
    tick(2 + D);
    soc_bus.exit_valid_i = 1'b1; soc_bus.exit_value_i = val;
    tick(1);
    soc_bus.exit_valid_i = 1'b0; btn_rst_i = 1'b0;
    m_state = S_HOLD; m_exit = 32'h0;
    total++; if (state_o !== m_state || soc_bus.done_o !== 1'b0) begin bad++; $display("FAIL coincide_state got=%0d/%0b want=%0d/0", state_o, soc_bus.done_o, m_state); end
    total++; if (soc_bus.exit_value_o !== m_exit) begin bad++; $display("FAIL coincide_exit got=%08h want=%08h", soc_bus.exit_value_o, m_exit); end
    tick(H);
    m_state = S_RUN;
    total++; if (state_o !== m_state) begin bad++; $display("FAIL coincide_run got=%0d want=%0d", state_o, m_state); end
    tick(D + 4);
    $display("test_coincide value=%08h done", val);
  endtask

  // Lock loss reaches WAIT_LOCK in 3 edges; exit value survives until HOLD.
  task automatic test_lock_drop(input logic boot_v, input logic flash_v);
    pll_locked_i = 1'b0;
    tick(3);
    m_state = S_WAIT;
    total++; if (state_o !== m_state || soc_rst_no !== 1'b0) begin bad++; $display("FAIL lockdrop_wait got=%0d/%0b want=%0d/0", state_o, soc_rst_no, m_state); end
    total++; if (soc_bus.exit_value_o !== m_exit) begin bad++; $display("FAIL lockdrop_exit got=%08h want=%08h", soc_bus.exit_value_o, m_exit); end
    test_boot(boot_v, flash_v);
    total++; if (soc_bus.exit_value_o !== m_exit) begin bad++; $display("FAIL relock_exit got=%08h want=%08h", soc_bus.exit_value_o, m_exit); end
    $display("test_lock_drop done");
  endtask

  task automatic test_reset_mid_hold();
    pll_locked_i = 1'b0; tick(3);
    pll_locked_i = 1'b1; tick(3);
    total++; if (state_o !== S_HOLD) begin bad++; $display("FAIL midhold_pre got=%0d want=%0d", state_o, S_HOLD); end
    tick(2);
    rst_n = 1'b0;
    #1;
    total++; if (state_o !== S_WAIT || soc_rst_no !== 1'b0 || soc_bus.done_o !== 1'b0) begin bad++; $display("FAIL midhold_async got=%0d/%0b/%0b want=0/0/0", state_o, soc_rst_no, soc_bus.done_o); end
    total++; if ({boot_select_o, execute_from_flash_o} !== 2'b00 || soc_bus.exit_value_o !== 32'h0) begin bad++; $display("FAIL midhold_outs got=%0b%0b/%08h want=00/00000000", boot_select_o, execute_from_flash_o, soc_bus.exit_value_o); end
    tick(2);
    rst_n = 1'b1;
    m_boot = 1'b0; m_flash = 1'b0; m_exit = 32'h0;
    test_boot(1'b1, 1'b0);
    $display("test_reset_mid_hold done");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      test_exit($urandom, int'($urandom_range(0, 6)));
      if ($urandom_range(0, 1) == 0)
        test_button(1'($urandom), 1'($urandom));
      else
        test_lock_drop(1'($urandom), 1'($urandom));
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_boot(1'b1, 1'($urandom));
    test_exit(32'h0000_0001, 2);
    test_exit_ignored();
    test_bounce();
    test_button(1'b0, 1'b1);
    test_coincide($urandom | 32'h1);
    test_exit($urandom, 1);
    test_lock_drop(1'b1, 1'b1);
    test_reset_mid_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpga_boot_sequencer.md
FPGA_BOOT_SEQUENCER -- requirements
Module: fpga_boot_sequencer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1024, meaning consecutive stable cycles before a button level is accepted (>=2).
REQ-002 SHALL have parameter HOLD_CYCLES, default 256, meaning SoC reset assertion length in cycles (>=2).
REQ-003 SHALL have port clk_gen  input  1  system clock from the clock wizard; all logic is on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port pll_locked_i  input  1  clock wizard lock, asynchronous to clk_gen.
REQ-006 SHALL have port btn_rst_i  input  1  raw push-button, active-high, asynchronous, bouncing.
REQ-007 SHALL have port boot_select_i  input  1  raw boot strap.
REQ-008 SHALL have port execute_from_flash_i  input  1  raw flash-execute strap.
REQ-009 SHALL have port exit_valid_i  input  1  SoC exit-valid flag, synchronous to clk_gen.
REQ-010 SHALL have port exit_value_i  input  32  SoC exit value.
REQ-011 SHALL have port soc_rst_no  output  1  SoC reset, active-low.
REQ-012 SHALL have port boot_select_o  output  1  latched boot strap.
REQ-013 SHALL have port execute_from_flash_o  output  1  latched flash strap.
REQ-014 SHALL have port exit_value_o  output  32  captured exit value.
REQ-015 SHALL have port done_o  output  1  high while in DONE.
REQ-016 SHALL have port state_o  output  2  encoded state for LEDs: WAIT_LOCK=0, HOLD=1, RUN=2, DONE=3.

Function
REQ-017 SHALL pass pll_locked_i and btn_rst_i each through a 2-flop synchronizer before use.
REQ-018 SHALL keep a debounced button level btn_db; it SHALL take the synchronized value only after that value differs from btn_db for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free cycle resets the counter.
REQ-019 SHALL generate btn_press as a one-cycle pulse on the 0->1 transition of btn_db.
REQ-020 SHALL implement FSM states WAIT_LOCK, HOLD, RUN, DONE.
REQ-021 WAIT_LOCK -> HOLD when synchronized lock is 1; hold counter cleared on entry.
REQ-022 HOLD SHALL count HOLD_CYCLES cycles, then enter RUN; the counter SHALL not wrap.
REQ-023 On the last HOLD cycle the module SHALL sample boot_select_i and execute_from_flash_i into boot_select_o/execute_from_flash_o; these SHALL stay constant outside HOLD.
REQ-024 soc_rst_no SHALL be 0 in WAIT_LOCK and HOLD, 1 in RUN and DONE, driven from a flop (no glitches).
REQ-025 RUN -> DONE on the first cycle exit_valid_i=1; exit_value_i SHALL be captured into exit_value_o on that same edge and held until the next HOLD entry.
REQ-026 In DONE further exit_valid_i pulses SHALL be ignored.
REQ-027 btn_press in RUN or DONE SHALL force HOLD; exit_value_o SHALL clear to 0 on HOLD entry; btn_press in WAIT_LOCK or HOLD SHALL be ignored.
REQ-028 Synchronized lock = 0 in any state SHALL force WAIT_LOCK next cycle, overriding btn_press and exit_valid_i.
REQ-029 If exit_valid_i and btn_press coincide in RUN, HOLD SHALL win and no capture SHALL occur.

Reset
REQ-030 While rst_n=0: state WAIT_LOCK, soc_rst_no=0, boot_select_o=0, execute_from_flash_o=0, exit_value_o=0, done_o=0, state_o=0, btn_db=0, all counters and synchronizers 0.
REQ-031 rst_n deassertion mid-operation SHALL restart from WAIT_LOCK; no other state SHALL be held over.

Verification
REQ-032 lock rises at t0, boot_select_i=1 -> HOLD at t0+3, soc_rst_no rises exactly HOLD_CYCLES later, boot_select_o=1.
REQ-033 exit_value_i=0x0000_0001 with exit_valid_i pulse in RUN -> DONE, done_o=1, exit_value_o=1; second pulse with 0xDEAD_BEEF -> exit_value_o unchanged.
REQ-034 button bounce of 10-cycle pulses (DEBOUNCE_CYCLES=16) -> no HOLD; button held 16+ cycles -> HOLD, soc_rst_no=0, exit_value_o=0.
REQ-035 lock drops in DONE -> WAIT_LOCK within 3 cycles, soc_rst_no=0; lock returns -> full HOLD sequence repeats.
REQ-036 exit_valid_i and btn_press in same RUN cycle -> HOLD, exit_value_o=0, done_o=0.
REQ-037 rst_n pulsed low during HOLD -> all outputs at REQ-030 values asynchronously, restart from WAIT_LOCK.
